// File: rtl/width_enum_pkg.sv
// rtl/width_enum_pkg.sv - shared enum code set, sequencer state encoding and code stepping
package width_enum_pkg;

  localparam logic [3:0] E0 = 4'h0;
  localparam logic [3:0] E1 = 4'd5;
  localparam logic [3:0] E2 = 4'd6;
  localparam logic [3:0] E3 = 4'h7;
  localparam logic [3:0] E4 = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_DWELL   = 2'd2
  } seq_state_e;

  // E4 and anything outside the run map to E0 so the caller can detect the end.
  function automatic logic [3:0] next_code(input logic [3:0] code);
    case (code)
      E1:      next_code = E2;
      E2:      next_code = E3;
      E3:      next_code = E4;
      default: next_code = E0;
    endcase
  endfunction

endpackage

// File: rtl/enum_dwell_timer.sv
// rtl/enum_dwell_timer.sv - loadable dwell down-counter with hold and expire strobe
module enum_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               hold,
  output logic               expire
);

  logic [DWELL_W-1:0] count_q, count_d;

  // Floor at 1 so the counter never wraps while the FSM sits in DWELL.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!hold && (count_q > DWELL_W'(1))) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == DWELL_W'(1)) && !hold;

endmodule

// File: rtl/enum_sequencer.sv
// rtl/enum_sequencer.sv - steps E1..E4 onto a valid/ready handshake with a dwell gap after each code
module enum_sequencer
  import width_enum_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  output logic [3:0]         e_code,
  output logic               e_valid,
  input  logic               e_ready,
  output logic               busy,
  output logic               done
);

  seq_state_e         state_q, state_d;
  logic [3:0]         code_q, code_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_q, done_d;
  logic               timer_load;
  logic               timer_expire;
  logic               advance;

  enum_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (dwell_q),
    .hold     (hold),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    dwell_d    = dwell_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dwell_d = dwell;
          code_d  = E1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (e_ready) begin
          if (dwell_q == '0) begin
            advance = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_d    = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (timer_expire) begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by the zero-dwell handshake and the dwell expiry.
    if (advance) begin
      if (code_q == E4) begin
        state_d = S_IDLE;
        code_d  = E0;
        done_d  = 1'b1;
      end else begin
        code_d  = next_code(code_q);
        state_d = S_PRESENT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= E0;
      dwell_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
    end
  end

  assign e_code  = code_q;
  assign e_valid = (state_q == S_PRESENT);
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
